// File: rtl/lifi_phy_pkg.sv
// Shared definitions for the LiFi PHY: receiver FSM states, the Sylvester
// Hadamard sign function and the width derivations used by the receiver.
package lifi_phy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } state_t;

    // Returns 1 when the Sylvester Hadamard entry h[k][j] is -1.
    function automatic logic hsign(input int k, input int j);
        return ^(k & j);
    endfunction

    function automatic int payload_bits(input int hadamard, input int pam_level_log);
        return (hadamard - 1) * pam_level_log;
    endfunction

    function automatic int frame_bits(input int bit_num, input int hadamard);
        return bit_num * hadamard;
    endfunction

    function automatic int acc_width(input int midle_bits);
        return midle_bits + 1;
    endfunction

endpackage

// File: rtl/walsh_correlator.sv
// Combinational correlation of one frame of unipolar samples against
// Sylvester Hadamard row `row`, producing the signed sum y_row.
module walsh_correlator
    import lifi_phy_pkg::*;
#(
    parameter int HADAMARD   = 16,
    parameter int BIT_NUM    = 7,
    parameter int MIDLE_BITS = 11
) (
    input  logic [BIT_NUM*HADAMARD-1:0] samples,
    input  logic [$clog2(HADAMARD)-1:0] row,
    output logic signed [MIDLE_BITS:0]  corr
);

    logic signed [MIDLE_BITS:0] term;

    always_comb begin
        corr = '0;
        term = '0;
        for (int k = 0; k < HADAMARD; k++) begin
            term = {{(MIDLE_BITS + 1 - BIT_NUM){1'b0}}, samples[k*BIT_NUM +: BIT_NUM]};
            if (hsign(k, int'(row))) begin
                corr = corr - term;
            end else begin
                corr = corr + term;
            end
        end
    end

endmodule

// File: rtl/hadamard_pam_receiver.sv
// Hadamard/PAM receiver: latches one sample frame, correlates it against
// rows 1..H-1 one per cycle and slices each result back to a PAM symbol.
module hadamard_pam_receiver
    import lifi_phy_pkg::*;
#(
    parameter int HADAMARD      = 16,
    parameter int PAM_LEVEL_LOG = 3,
    parameter int BIT_NUM       = 7,
    parameter int MIDLE_BITS    = 11,
    localparam int N = payload_bits(HADAMARD, PAM_LEVEL_LOG),
    localparam int M = frame_bits(BIT_NUM, HADAMARD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [M-1:0] input_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] output_data,
    output logic         out_valid
);

    localparam int LOG_H = $clog2(HADAMARD);
    localparam int ACC_W = acc_width(MIDLE_BITS);
    localparam int L     = PAM_LEVEL_LOG;
    localparam int P_MAX = (1 << PAM_LEVEL_LOG) - 1;

    state_t               state_q, state_d;
    logic [M-1:0]         samples_q, samples_d;
    logic [LOG_H-1:0]     idx_q, idx_d;
    logic [N-1:0]         out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] corr;
    logic [ACC_W-1:0]     rounded;
    logic [L-1:0]         sym;

    walsh_correlator #(
        .HADAMARD   (HADAMARD),
        .BIT_NUM    (BIT_NUM),
        .MIDLE_BITS (MIDLE_BITS)
    ) u_corr (
        .samples (samples_q),
        .row     (idx_q),
        .corr    (corr)
    );

    // y = (H/2)*s, so rounding to nearest is (y + H/4) >> (log2(H)-1).
    always_comb begin
        rounded = $unsigned(corr) + ACC_W'(HADAMARD / 4);
        rounded = rounded >> (LOG_H - 1);
        sym     = '0;
        if (!corr[ACC_W-1]) begin
            sym = (rounded > ACC_W'(P_MAX)) ? L'(P_MAX) : rounded[L-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        samples_d   = samples_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    samples_d = input_data;
                    idx_d     = LOG_H'(1);
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                for (int s = 0; s < HADAMARD - 1; s++) begin
                    if (idx_q == LOG_H'(s + 1)) begin
                        out_data_d[s*L +: L] = sym;
                    end
                end
                if (idx_q == LOG_H'(HADAMARD - 1)) begin
                    idx_d       = LOG_H'(1);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + LOG_H'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            samples_q   <= '0;
            idx_q       <= LOG_H'(1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            samples_q   <= samples_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign output_data = out_data_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_hadamard_pam_receiver.sv
// Scoreboard bench for hadamard_pam_receiver: accepted frames are decoded by an
// arithmetic reference model and compared when the receiver signals out_valid.
module tb_hadamard_pam_receiver;

    localparam int H  = 16;
    localparam int L  = 3;
    localparam int BN = 7;
    localparam int N  = (H - 1) * L;
    localparam int M  = BN * H;
    localparam int P  = 1 << L;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [M-1:0] input_data = '0;
    logic         in_ready;
    logic [N-1:0] output_data;
    logic         out_valid;

    hadamard_pam_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .output_data (output_data),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        int           cyc;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   busy_until = 0;
    int   last_accept = -1;
    exp_t exp_q[$];
    int   dut_accepts[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // y_j = sum_k h_kj x_k, then round y/(H/2) to nearest, clamp to 0..P-1.
    function automatic logic [N-1:0] decode_model(input logic [M-1:0] frame);
        logic [N-1:0] res;
        int y;
        int s;
        res = '0;
        for (int j = 1; j < H; j++) begin
            y = 0;
            for (int k = 0; k < H; k++) begin
                if ($countones(k & j) % 2 == 0) y += int'(frame[k*BN +: BN]);
                else                            y -= int'(frame[k*BN +: BN]);
            end
            if (y < 0) s = 0;
            else       s = (y + H / 4) / (H / 2);
            if (s > P - 1) s = P - 1;
            res[(j-1)*L +: L] = L'(s);
        end
        return res;
    endfunction

    function automatic logic [M-1:0] encode(input logic [N-1:0] syms);
        logic [M-1:0] frame;
        int x;
        frame = '0;
        for (int k = 0; k < H; k++) begin
            x = 0;
            for (int j = 1; j < H; j++) begin
                if ($countones(k & j) % 2 == 0) x += int'(syms[(j-1)*L +: L]);
            end
            frame[k*BN +: BN] = BN'(x);
        end
        return frame;
    endfunction

    function automatic logic [N-1:0] rand_syms();
        logic [N-1:0] syms;
        syms = '0;
        for (int j = 0; j < H - 1; j++) syms[j*L +: L] = L'($urandom_range(0, P - 1));
        return syms;
    endfunction

    function automatic logic [M-1:0] rand_frame();
        logic [M-1:0] frame;
        frame = '0;
        for (int k = 0; k < H; k++) frame[k*BN +: BN] = BN'($urandom_range(0, (1 << BN) - 1));
        return frame;
    endfunction

    // Reference timing: busy for H cycles after each accept, reset frees it.
    always @(posedge clk) begin
        if (in_valid && in_ready && !reset) dut_accepts.push_back(cycle + 1);
        cycle <= cycle + 1;
        if (reset) begin
            exp_q.delete();
            busy_until <= cycle + 1;
        end else if (in_valid && cycle >= busy_until) begin
            exp_q.push_back('{decode_model(input_data), cycle + H});
            busy_until  <= cycle + 1 + H;
            last_accept <= cycle + 1;
        end
    end

    always @(negedge clk) begin
        if (cycle > 0) begin
            checkOutput("in_ready", 64'(in_ready), 64'(cycle >= busy_until));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    checkOutput("frame_data", 64'(output_data), 64'(exp_q[0].data));
                    checkOutput("frame_latency", 64'(cycle), 64'(exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && cycle >= exp_q[0].cyc) begin
                checkOutput("out_valid_missing", 64'(out_valid), 64'(1));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [M-1:0] frame, input bit hold);
        int prev;
        bit accepted;
        prev = last_accept;
        accepted = 1'b0;
        @(negedge clk);
        input_data = frame;
        in_valid   = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (last_accept != prev) begin
                accepted = 1'b1;
                break;
            end
        end
        checkOutput("frame_accepted", 64'(accepted), 64'(1));
        if (!hold) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic expectFrame(input string name, input logic [N-1:0] req);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_valid"}, 64'(seen), 64'(1));
        if (seen) checkOutput(name, 64'(output_data), 64'(req));
    endtask

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [M-1:0] frame;
        logic [N-1:0] expv;
        logic [N-1:0] syms;
        int           n0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_output_data", 64'(output_data), 64'(0));
        reset = 1'b0;

        applyStimulus('0, 1'b0);
        expectFrame("all_zero", '0);

        frame = '0;
        for (int k = 0; k < H; k += 2) frame[k*BN +: BN] = BN'(7);
        expv = '0;
        expv[L-1:0] = '1;
        applyStimulus(frame, 1'b0);
        expectFrame("s1_only", expv);

        frame = '0;
        for (int k = 0; k < H; k++) frame[k*BN +: BN] = (k == 0) ? BN'(105) : BN'(49);
        applyStimulus(frame, 1'b0);
        expectFrame("all_sevens", '1);

        frame = '0;
        frame[1*BN +: BN] = BN'(127);
        expv = '0;
        for (int j = 2; j < H; j += 2) expv[(j-1)*L +: L] = '1;
        applyStimulus(frame, 1'b0);
        expectFrame("x1_saturate", expv);

        frame = '0;
        frame[BN-1:0] = BN'(127);
        applyStimulus(frame, 1'b0);
        expectFrame("x0_saturate", '1);

        // Back-to-back with a junk frame presented while the first decodes.
        n0   = dut_accepts.size();
        syms = rand_syms();
        applyStimulus(encode(rand_syms()), 1'b1);
        @(negedge clk);
        input_data = rand_frame();
        repeat (6) @(negedge clk);
        applyStimulus(encode(syms), 1'b0);
        if (dut_accepts.size() >= n0 + 2)
            checkOutput("b2b_spacing", 64'(dut_accepts[n0+1] - dut_accepts[n0]), 64'(H + 1));
        else
            checkOutput("b2b_accepts", 64'(dut_accepts.size()), 64'(n0 + 2));
        expectFrame("b2b_second", syms);

        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i % 2 == 0) begin
                syms = rand_syms();
                applyStimulus(encode(syms), 1'b0);
                expectFrame("golden", syms);
            end else begin
                applyStimulus(rand_frame(), 1'b0);
            end
        end
        repeat (20) @(negedge clk);

        // Abort in the middle of decoding.
        applyStimulus(encode(rand_syms()), 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
        checkOutput("abort_output_data", 64'(output_data), 64'(0));
        checkOutput("abort_in_ready", 64'(in_ready), 64'(1));
        repeat (20) @(negedge clk);
        syms = rand_syms();
        applyStimulus(encode(syms), 1'b0);
        expectFrame("after_abort", syms);

        // Reset coinciding with a valid frame drops the frame.
        @(negedge clk);
        reset      = 1'b1;
        in_valid   = 1'b1;
        input_data = encode(rand_syms());
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (25) @(negedge clk);
        checkOutput("reset_drop_output_data", 64'(output_data), 64'(0));

        syms = rand_syms();
        applyStimulus(encode(syms), 1'b0);
        expectFrame("final", syms);
        repeat (25) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
